// File: rtl/sysid_pkg.sv
// Shared word map and CAPS layout for the system identification register file.
package sysid_pkg;

  localparam logic [31:0] ADDR_SYSID     = 32'd0;
  localparam logic [31:0] ADDR_TIMESTAMP = 32'd1;
  localparam logic [31:0] ADDR_VERSION   = 32'd2;
  localparam logic [31:0] ADDR_SCRATCH   = 32'd3;
  localparam logic [31:0] ADDR_UPTIME_LO = 32'd4;
  localparam logic [31:0] ADDR_UPTIME_HI = 32'd5;
  localparam logic [31:0] ADDR_CAPS      = 32'd6;
  localparam logic [31:0] ADDR_RSVD      = 32'd7;
  localparam logic [31:0] ADDR_USER_BASE = 32'd8;

  localparam int MAX_USER = 8;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  num_user;
    logic [7:0]  addr_w;
  } caps_t;

  function automatic logic [31:0] pack_caps(input int num_user, input int addr_w);
    caps_t c;
    c.rsvd     = '0;
    c.num_user = 8'(num_user);
    c.addr_w   = 8'(addr_w);
    return c;
  endfunction

endpackage

// File: rtl/sysid_uptime.sv
// 64-bit free-running uptime counter with a HI shadow latched when the LO word is read,
// so a LO-then-HI read pair always sees one coherent 64-bit sample.
module sysid_uptime #(
  parameter logic [63:0] PRESET = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] hi_shadow
);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;

  always_comb begin
    cnt_d = cnt_q + 64'd1;
    hi_d  = snap ? cnt_q[63:32] : hi_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= PRESET;
      hi_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign count_lo  = cnt_q[31:0];
  assign hi_shadow = hi_q;

endmodule

// File: rtl/sysid_regfile.sv
// Avalon-MM system identification register file: constant IDs, scratch word, uptime
// counter, capabilities and user ID words behind a fixed 1-cycle registered read.
module sysid_regfile
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter logic [31:0] VERSION       = 32'h0001_0000,
  parameter int          NUM_USER      = 4,
  parameter int          ADDR_W        = 4,
  // Reset load of the uptime counter; leave at zero in real builds.
  parameter logic [63:0] UPTIME_PRESET = 64'h0,
  localparam int         UW            = (NUM_USER > 0) ? NUM_USER : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [32*UW-1:0]  user_id,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [31:0] addr_ext;
  logic [31:0] mux_data;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;
  logic        snap;
  logic [31:0] up_lo, up_hi;

  assign addr_ext = 32'(address);
  assign snap     = read & (addr_ext == ADDR_UPTIME_LO);

  sysid_uptime #(.PRESET(UPTIME_PRESET)) u_uptime (
    .clock     (clock),
    .reset     (reset),
    .snap      (snap),
    .count_lo  (up_lo),
    .hi_shadow (up_hi)
  );

  always_comb begin
    mux_data = '0;
    case (addr_ext)
      ADDR_SYSID:     mux_data = SYSTEM_ID;
      ADDR_TIMESTAMP: mux_data = TIMESTAMP;
      ADDR_VERSION:   mux_data = VERSION;
      ADDR_SCRATCH:   mux_data = scratch_q;
      ADDR_UPTIME_LO: mux_data = up_lo;
      ADDR_UPTIME_HI: mux_data = up_hi;
      ADDR_CAPS:      mux_data = pack_caps(NUM_USER, ADDR_W);
      default:        mux_data = '0;
    endcase
    for (int k = 0; k < NUM_USER; k++) begin
      if (addr_ext == ADDR_USER_BASE + 32'(k)) mux_data = user_id[32*k +: 32];
    end
  end

  // Mux reads the pre-write scratch value, so a same-cycle read+write returns old data.
  always_comb begin
    scratch_d  = (write && addr_ext == ADDR_SCRATCH) ? writedata : scratch_q;
    readdata_d = read ? mux_data : readdata_q;
    rdv_d      = read;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q  <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sysid_regfile.sv
// Bench for sysid_regfile: two instances (4 user words, and 1 user word with a preset
// uptime counter near the 32-bit boundary) driven in lockstep against a reference model.
module tb_sysid_regfile;

  localparam logic [31:0] SYSID  = 32'h56E2_A27A;
  localparam logic [31:0] TSTAMP = 32'h56E2_A27A;
  localparam logic [31:0] VER    = 32'h0001_0000;
  localparam logic [63:0] PRE1   = 64'h0000_0000_FFFF_FFFE;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]   address   = '0;
  logic         read      = 1'b0;
  logic         write     = 1'b0;
  logic [31:0]  writedata = '0;
  logic [127:0] user_id   = '0;
  logic [31:0]  rd4, rd1;
  logic         rdv4, rdv1;

  sysid_regfile #(
    .SYSTEM_ID(SYSID), .TIMESTAMP(TSTAMP), .NUM_USER(4), .ADDR_W(4)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .user_id(user_id), .readdata(rd4), .readdatavalid(rdv4)
  );

  sysid_regfile #(
    .SYSTEM_ID(SYSID), .TIMESTAMP(TSTAMP), .NUM_USER(1), .ADDR_W(4), .UPTIME_PRESET(PRE1)
  ) dut1 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .user_id(user_id[31:0]), .readdata(rd1), .readdatavalid(rdv1)
  );

  // reference model state and scoreboard
  int tests = 0;
  int fails = 0;
  logic [63:0] m_cnt4, m_cnt1;
  logic [31:0] m_hi4, m_hi1, m_scr, m_last4, m_last1;
  logic [31:0] exp_q4[$];
  logic [31:0] exp_q1[$];

  function automatic logic [31:0] ref_word(input int a, input int nu, input logic [63:0] cnt,
                                           input logic [31:0] hi, input logic [31:0] scr,
                                           input logic [127:0] uid);
    if (a == 0) return SYSID;
    if (a == 1) return TSTAMP;
    if (a == 2) return VER;
    if (a == 3) return scr;
    if (a == 4) return cnt[31:0];
    if (a == 5) return hi;
    if (a == 6) return {16'h0, 8'(nu), 8'd4};
    if (a >= 8 && a < 8 + nu) return uid[32*(a-8) +: 32];
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one bus cycle, then check the response one cycle later
  task automatic step(input logic rst, input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] wd, input string tag);
    logic rd_ok;
    reset = rst; read = rd; write = wr; address = a; writedata = wd;
    rd_ok = rd && !rst;
    if (rd_ok) begin
      exp_q4.push_back(ref_word(int'(a), 4, m_cnt4, m_hi4, m_scr, user_id));
      exp_q1.push_back(ref_word(int'(a), 1, m_cnt1, m_hi1, m_scr, user_id));
    end
    @(posedge clock);
    if (rst) begin
      m_cnt4 = 64'h0; m_cnt1 = PRE1; m_hi4 = '0; m_hi1 = '0;
      m_scr = '0; m_last4 = '0; m_last1 = '0;
      exp_q4.delete(); exp_q1.delete();
    end else begin
      if (rd && a == 4'd4) begin
        m_hi4 = m_cnt4[63:32];
        m_hi1 = m_cnt1[63:32];
      end
      m_cnt4 = m_cnt4 + 64'd1;
      m_cnt1 = m_cnt1 + 64'd1;
      if (wr && a == 4'd3) m_scr = wd;
    end
    @(negedge clock);
    if (rd_ok) begin
      m_last4 = exp_q4.pop_front();
      m_last1 = exp_q1.pop_front();
    end
    chk({tag, "/rdv4"}, {31'b0, rdv4}, {31'b0, rd_ok});
    chk({tag, "/rdv1"}, {31'b0, rdv1}, {31'b0, rd_ok});
    chk({tag, "/data4"}, rd4, m_last4);
    chk({tag, "/data1"}, rd1, m_last1);
  endtask

  initial begin
    logic r, w;
    logic [3:0] a;
    @(negedge clock);
    step(1, 0, 0, 4'd0, 32'h0, "reset0");
    step(1, 0, 0, 4'd0, 32'h0, "reset1");

    // uptime: first cycles after reset, then coherent HI across a LO wrap
    step(0, 1, 0, 4'd4, 32'h0, "up_lo0");
    step(0, 1, 0, 4'd4, 32'h0, "up_lo1");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'd0, 32'h0, "idle");
    step(0, 1, 0, 4'd5, 32'h0, "up_hi");

    // back-to-back ID reads, then held data
    step(0, 1, 0, 4'd0, 32'h0, "rd_sysid");
    step(0, 1, 0, 4'd1, 32'h0, "rd_tstamp");
    step(0, 0, 0, 4'd2, 32'h0, "hold");

    // scratch write, read, read+write collision
    step(0, 0, 1, 4'd3, 32'hDEAD_BEEF, "wr_scr");
    step(0, 1, 0, 4'd3, 32'h0, "rd_scr");
    step(0, 1, 1, 4'd3, 32'h1234_5678, "rdwr_scr");
    step(0, 1, 0, 4'd3, 32'h0, "rd_scr2");

    // reserved words, user words, ignored writes, CAPS and VERSION
    user_id = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    step(0, 1, 0, 4'd7, 32'h0, "rd_rsvd7");
    step(0, 1, 0, 4'd9, 32'h0, "rd_user9");
    step(0, 1, 0, 4'd15, 32'h0, "rd_rsvd15");
    step(0, 0, 1, 4'd0, 32'hFFFF_FFFF, "wr_sysid");
    step(0, 1, 0, 4'd0, 32'h0, "rd_sysid2");
    step(0, 1, 0, 4'd10, 32'h0, "rd_user10");
    step(0, 1, 0, 4'd6, 32'h0, "rd_caps");
    step(0, 1, 0, 4'd2, 32'h0, "rd_version");

    // read dropped by reset, scratch cleared
    step(1, 1, 0, 4'd3, 32'h0, "rst_read");
    step(0, 1, 0, 4'd3, 32'h0, "rd_scr_rst");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      user_id = {$urandom, $urandom, $urandom, $urandom};
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 4'd3;
      step(($urandom_range(0, 40) == 0), r, w, a, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysid_regfile.md
SYSID_REGFILE -- requirements
Module: sysid_regfile

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h0000_0000: value returned at word 0.
REQ-002 Parameter TIMESTAMP, default 32'h0000_0000: build timestamp returned at word 1.
REQ-003 Parameter VERSION, default 32'h0001_0000: block version ({major[15:0], minor[15:0]}) returned at word 2.
REQ-004 Parameter NUM_USER, default 4, legal range 0..8: number of user ID words mapped from word 8 upward.
REQ-005 Parameter ADDR_W, default 4: word address width; SHALL satisfy 2^ADDR_W >= 8+NUM_USER.
REQ-006 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 address  in  ADDR_W  Avalon-MM word address.
REQ-009 read  in  1  read strobe, single cycle per transfer.
REQ-010 write  in  1  write strobe, single cycle per transfer.
REQ-011 writedata  in  32  write data.
REQ-012 user_id  in  32*max(NUM_USER,1)  user words, word k in bits [32k+31:32k], sampled at read time.
REQ-013 readdata  out  32  registered read data.
REQ-014 readdatavalid  out  1  one-cycle pulse qualifying readdata.

Function
REQ-015 Map: 0 SYSTEM_ID; 1 TIMESTAMP; 2 VERSION; 3 SCRATCH (R/W); 4 UPTIME_LO; 5 UPTIME_HI; 6 CAPS = {16'h0, 8'(NUM_USER), 8'(ADDR_W)}; 7 reserved; 8..8+NUM_USER-1 user_id[k]; all other addresses reserved.
REQ-016 Reserved addresses SHALL read 0; writes to any address other than 3 SHALL be ignored.
REQ-017 Read latency SHALL be fixed at 1: read at cycle N gives readdatavalid=1 and valid readdata at N+1; readdatavalid=0 otherwise.
REQ-018 readdata SHALL hold its last value when readdatavalid=0.
REQ-019 Back-to-back reads on consecutive cycles SHALL each return data one cycle later, with no bubble.
REQ-020 Write to word 3 SHALL update SCRATCH at the clock edge of the write cycle.
REQ-021 Read and write asserted in the same cycle: write SHALL take effect; read SHALL return the pre-write value.
REQ-022 A 64-bit free-running counter SHALL increment by 1 every cycle out of reset, wrapping from 2^64-1 to 0.
REQ-023 A read of word 4 SHALL return counter[31:0] as sampled in the read cycle and SHALL latch counter[63:32] of the same cycle into a HI shadow register.
REQ-024 A read of word 5 SHALL return the HI shadow, not the live counter.
REQ-025 Counter wrap of the low word between LO and HI reads SHALL NOT corrupt the returned 64-bit value.

Reset
REQ-026 On reset: readdata=0, readdatavalid=0, SCRATCH=0, counter=0, HI shadow=0.
REQ-027 A read issued in the cycle reset is asserted SHALL be dropped (no readdatavalid the next cycle).
REQ-028 Counter SHALL read 0 in the first cycle after reset deasserts and 1 in the following cycle.

Structure
REQ-029 Shared package sysid_pkg SHALL hold the word-offset constants (ADDR_SYSID..ADDR_USER_BASE) and the CAPS field layout.
REQ-030 Counter plus HI shadow SHALL be one sub-module, sysid_uptime, with ports clock, reset, snap, count_lo, hi_shadow.
REQ-031 Read mux SHALL be combinational, feeding a single output register stage; no other pipelining.

Verification
REQ-032 SYSTEM_ID=32'h56E2_A27A, TIMESTAMP=32'h56E2_A27A: read 0 then 1 back-to-back -> both words returned on consecutive cycles, readdatavalid high two cycles.
REQ-033 Write 32'hDEAD_BEEF to 3, then read 3 -> 32'hDEAD_BEEF; simultaneous read+write 32'h1234_5678 -> read returns 32'hDEAD_BEEF, next read 32'h1234_5678.
REQ-034 Force counter to 64'h0000_0000_FFFF_FFFE, read 4 then after 5 cycles read 5 -> 32'hFFFF_FFFE then 32'h0000_0000.
REQ-035 Read 7, 9 with NUM_USER=1, and 15 -> 0; write 32'hFFFF_FFFF to 0 -> word 0 still SYSTEM_ID.
REQ-036 Assert reset in the same cycle as a read -> readdatavalid stays 0 next cycle; SCRATCH reads 0 afterwards.
REQ-037 NUM_USER=4, user_id word2=32'hCAFE_0002: read 10 -> 32'hCAFE_0002; read 6 -> 32'h0000_0404.
